// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents:
//   CPU_WORD_WIDTH - instruction and address width
//   fetch_state_e  - fetch FSM encodings (IDLE=0, REQ=1, DRAIN=2)
//   TRAP_INSTR     - the all-zero trap word; fetch passes it through untouched
//   fetch_in_range - legal-address test against an inclusive upper limit
package instruction_fetch_unit_pkg;

    localparam int unsigned CPU_WORD_WIDTH = 20;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [CPU_WORD_WIDTH-1:0] TRAP_INSTR = '0;

    function automatic logic fetch_in_range(
        input logic [CPU_WORD_WIDTH-1:0] addr,
        input logic [CPU_WORD_WIDTH-1:0] limit
    );
        return addr <= limit;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_timeout_counter.sv
// Wait-cycle counter for the fetch unit's memory handshake.
// Ports:
//   clk_i     - clock, rising edge
//   rst_ni    - synchronous active-low reset
//   clear_i   - restart the count (held while idle and on redirect)
//   enable_i  - count this cycle (a cycle spent waiting with mem_valid low)
//   expired_o - high in the cycle whose count would reach LIMIT
module fetch_timeout_counter #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flagged one cycle early so the FSM can abort on the very edge at
    // which the count reaches LIMIT; a clear (redirect) restarts the wait.
    assign expired_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads one instruction per fetch
// request from instruction memory and hands it to the control unit.
// Ports:
//   clk, reset (sync, active-low)
//   fetch_enable, jump_enable, jump_target, clear_flags - control unit side
//   mem_req, mem_addr, mem_valid, mem_rdata             - memory side
//   instruction, instr_valid, pc, busy                  - fetch results
//   mem_violation_flag, mem_corruption_flag             - sticky error flags
//   dbg_state_o                                         - current FSM state
//
// Memory handshake: mem_req is a registered request that stays high, with
// mem_addr stable, until mem_valid is sampled high on a rising edge; that
// edge completes the transfer and mem_req drops on it. mem_valid is ignored
// whenever mem_req is low.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned            WORD_WIDTH = CPU_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0]  MEM_LIMIT  = 20'h003FF,
    parameter logic [WORD_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_enable,
    input  logic                  jump_enable,
    input  logic [WORD_WIDTH-1:0] jump_target,
    input  logic                  clear_flags,
    output logic                  mem_req,
    output logic [WORD_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic                  instr_valid,
    output logic [WORD_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  mem_violation_flag,
    output logic                  mem_corruption_flag,
    output fetch_state_e          dbg_state_o
);

    localparam logic [WORD_WIDTH-1:0] ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e          state_q;
    logic [WORD_WIDTH-1:0] pc_q;
    logic [WORD_WIDTH-1:0] instr_q;
    logic [WORD_WIDTH-1:0] mem_addr_q;
    logic                  mem_req_q;
    logic                  instr_valid_q;
    logic                  busy_q;
    logic                  violation_q;
    logic                  corruption_q;

    logic [WORD_WIDTH-1:0] fetch_addr;
    logic                  wait_clear;
    logic                  wait_enable;
    logic                  wait_expired;

    // A jump in the same IDLE cycle redirects the fetch immediately.
    assign fetch_addr = jump_enable ? jump_target : pc_q;

    // Wait count restarts on entry to REQ (held clear in IDLE) and on entry
    // to DRAIN (redirect while in REQ).
    assign wait_clear  = (state_q == FETCH_IDLE) || ((state_q == FETCH_REQ) && jump_enable);
    assign wait_enable = (state_q != FETCH_IDLE) && !mem_valid;

    fetch_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (wait_clear),
        .enable_i  (wait_enable),
        .expired_o (wait_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= TRAP_INSTR;
            mem_addr_q    <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            violation_q   <= 1'b0;
            corruption_q  <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;

            // Flag sets below are written later, so a set in the same cycle wins.
            if (clear_flags) begin
                violation_q  <= 1'b0;
                corruption_q <= 1'b0;
            end

            case (state_q)
                FETCH_IDLE: begin
                    if (jump_enable) begin
                        pc_q <= jump_target;
                    end
                    if (fetch_enable) begin
                        if (!fetch_in_range(fetch_addr, MEM_LIMIT)) begin
                            violation_q <= 1'b1;
                        end else begin
                            state_q    <= FETCH_REQ;
                            mem_req_q  <= 1'b1;
                            busy_q     <= 1'b1;
                            mem_addr_q <= fetch_addr;
                        end
                    end
                end

                FETCH_REQ: begin
                    if (jump_enable) begin
                        pc_q <= jump_target;
                    end
                    if (mem_valid) begin
                        // Response and redirect on the same edge: the
                        // response is stale, so it is dropped.
                        state_q   <= FETCH_IDLE;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        if (!jump_enable) begin
                            instr_q       <= mem_rdata;
                            instr_valid_q <= 1'b1;
                            pc_q          <= mem_addr_q + ONE;
                        end
                    end else if (wait_expired) begin
                        state_q      <= FETCH_IDLE;
                        mem_req_q    <= 1'b0;
                        busy_q       <= 1'b0;
                        corruption_q <= 1'b1;
                    end else if (jump_enable) begin
                        state_q <= FETCH_DRAIN;
                    end
                end

                FETCH_DRAIN: begin
                    if (jump_enable) begin
                        pc_q <= jump_target;
                    end
                    if (mem_valid) begin
                        state_q   <= FETCH_IDLE;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (wait_expired) begin
                        state_q      <= FETCH_IDLE;
                        mem_req_q    <= 1'b0;
                        busy_q       <= 1'b0;
                        corruption_q <= 1'b1;
                    end
                end

                default: begin
                    state_q   <= FETCH_IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req             = mem_req_q;
    assign mem_addr            = mem_addr_q;
    assign instruction         = instr_q;
    assign instr_valid         = instr_valid_q;
    assign pc                  = pc_q;
    assign busy                = busy_q;
    assign mem_violation_flag  = violation_q;
    assign mem_corruption_flag = corruption_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam int W = 20;
    localparam logic [W-1:0] LIMIT = 20'h003FF;
    localparam int TMO = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         fetch_enable;
    logic         jump_enable;
    logic [W-1:0] jump_target;
    logic         clear_flags;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_valid;
    logic [W-1:0] mem_rdata;
    logic [W-1:0] instruction;
    logic         instr_valid;
    logic [W-1:0] pc;
    logic         busy;
    logic         viol;
    logic         corr;
    fetch_state_e dbg_state;

    instruction_fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_enable        (fetch_enable),
        .jump_enable         (jump_enable),
        .jump_target         (jump_target),
        .clear_flags         (clear_flags),
        .mem_req             (mem_req),
        .mem_addr            (mem_addr),
        .mem_valid           (mem_valid),
        .mem_rdata           (mem_rdata),
        .instruction         (instruction),
        .instr_valid         (instr_valid),
        .pc                  (pc),
        .busy                (busy),
        .mem_violation_flag  (viol),
        .mem_corruption_flag (corr),
        .dbg_state_o         (dbg_state)
    );

    // ---------------- reference model state ----------------
    logic [W-1:0] mem [0:1023];
    logic [W-1:0] pc_m;
    logic [W-1:0] instr_m;
    logic         viol_m;
    logic         corr_m;
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    // ---------------- checkers ----------------
    task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge. Any
    // instr_valid pulse is matched against the scoreboard queue.
    task automatic step();
        logic [W-1:0] exp_word;
        @(posedge clk);
        #1;
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check1("spurious_instr_valid", instr_valid, 1'b0);
            end else begin
                exp_word = exp_q.pop_front();
                checkw("instr_data", instruction, exp_word);
            end
        end
    endtask

    task automatic check_model(input string tag);
        checkw({tag, "_pc"}, pc, pc_m);
        check1({tag, "_viol"}, viol, viol_m);
        check1({tag, "_corr"}, corr, corr_m);
        checkw({tag, "_instr"}, instruction, instr_m);
    endtask

    // ---------------- driver tasks ----------------
    // Fetch (optionally redirected by a same-cycle jump); memory answers after
    // 'delay' waiting cycles, or never when delay >= TMO.
    task automatic do_fetch(input logic jmp, input logic [W-1:0] tgt, input int delay);
        logic [W-1:0] addr;
        logic [W-1:0] data;
        int waits;
        addr = jmp ? tgt : pc_m;
        fetch_enable = 1'b1;
        jump_enable  = jmp;
        jump_target  = tgt;
        step();
        fetch_enable = 1'b0;
        jump_enable  = 1'b0;
        pc_m = addr;
        if (addr > LIMIT) begin
            viol_m = 1'b1;
            check1("viol_flag", viol, 1'b1);
            check1("viol_no_req", mem_req, 1'b0);
            checkw("viol_pc", pc, pc_m);
            return;
        end
        check1("req_high", mem_req, 1'b1);
        check1("req_busy", busy, 1'b1);
        checkw("req_addr", mem_addr, addr);
        waits = (delay >= TMO) ? TMO : delay;
        for (int i = 1; i <= waits; i++) begin
            step();
            if (i < TMO) begin
                check1("req_held", mem_req, 1'b1);
            end
        end
        if (delay >= TMO) begin
            corr_m = 1'b1;
            check1("tmo_req_low", mem_req, 1'b0);
            check1("tmo_corr", corr, 1'b1);
            check1("tmo_busy", busy, 1'b0);
            checkw("tmo_pc", pc, pc_m);
            return;
        end
        data = mem[addr[9:0]];
        exp_q.push_back(data);
        mem_valid = 1'b1;
        mem_rdata = data;
        step();
        mem_valid = 1'b0;
        mem_rdata = W'($urandom);
        instr_m = data;
        pc_m = addr + 20'd1;
        check1("done_valid", instr_valid, 1'b1);
        check1("done_req_low", mem_req, 1'b0);
        check1("done_busy", busy, 1'b0);
        checkw("done_pc", pc, pc_m);
    endtask

    // Fetch from pc, redirected by a jump after k waiting cycles; the
    // response arrives m cycles after the redirect and must be discarded.
    task automatic do_jump_fetch(input logic [W-1:0] tgt, input int k, input int m,
                                 input logic redo, input logic [W-1:0] tgt2);
        fetch_enable = 1'b1;
        step();
        fetch_enable = 1'b0;
        check1("jf_req", mem_req, 1'b1);
        checkw("jf_addr", mem_addr, pc_m);
        repeat (k) step();
        jump_enable = 1'b1;
        jump_target = tgt;
        step();
        jump_enable = 1'b0;
        pc_m = tgt;
        check1("drain_req", mem_req, 1'b1);
        checkw("drain_pc", pc, pc_m);
        checkw("drain_state", W'(dbg_state), W'(FETCH_DRAIN));
        for (int i = 0; i < m; i++) begin
            if (redo && i == 0) begin
                jump_enable = 1'b1;
                jump_target = tgt2;
                pc_m = tgt2;
            end
            step();
            jump_enable = 1'b0;
        end
        mem_valid = 1'b1;
        mem_rdata = W'($urandom);
        step();
        mem_valid = 1'b0;
        check1("discard_no_valid", instr_valid, 1'b0);
        check1("discard_req_low", mem_req, 1'b0);
        checkw("discard_instr", instruction, instr_m);
        checkw("discard_pc", pc, pc_m);
    endtask

    task automatic do_jump(input logic [W-1:0] tgt);
        jump_enable = 1'b1;
        jump_target = tgt;
        step();
        jump_enable = 1'b0;
        pc_m = tgt;
        checkw("jump_pc", pc, pc_m);
        check1("jump_no_req", mem_req, 1'b0);
    endtask

    task automatic do_clear();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        viol_m = 1'b0;
        corr_m = 1'b0;
        check1("clear_viol", viol, 1'b0);
        check1("clear_corr", corr, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int kind;
        for (int i = 0; i < 1024; i++) mem[i] = W'($urandom);
        mem[0]     = 20'b00100110010100000010;
        mem['h30]  = TRAP_INSTR;

        reset        = 1'b0;
        fetch_enable = 1'b0;
        jump_enable  = 1'b0;
        jump_target  = '0;
        clear_flags  = 1'b0;
        mem_valid    = 1'b0;
        mem_rdata    = '0;
        pc_m    = '0;
        instr_m = '0;
        viol_m  = 1'b0;
        corr_m  = 1'b0;

        // Reset values
        step();
        step();
        check_model("reset");
        check1("reset_req", mem_req, 1'b0);
        check1("reset_valid", instr_valid, 1'b0);
        check1("reset_busy", busy, 1'b0);
        checkw("reset_addr", mem_addr, '0);
        reset = 1'b1;
        step();

        // Basic fetch at PC 0, answer in first REQ cycle (2-cycle latency)
        do_fetch(1'b0, '0, 0);
        check_model("basic");

        // Jump during fetch, response 3 cycles after the jump
        do_jump_fetch(20'h00002, 0, 2, 1'b0, '0);
        do_fetch(1'b0, '0, 1);
        check_model("after_jump");

        // Simultaneous jump and fetch
        do_fetch(1'b1, 20'h00010, 1);
        checkw("sim_pc17", pc, 20'd17);

        // Stray mem_valid while idle
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        check1("stray_valid", instr_valid, 1'b0);

        // Out-of-range fetch, then clear
        do_jump(20'h00400);
        do_fetch(1'b0, '0, 0);
        check_model("oor");
        do_clear();

        // Set wins over clear in the same cycle
        fetch_enable = 1'b1;
        jump_enable  = 1'b1;
        jump_target  = 20'h00500;
        clear_flags  = 1'b1;
        step();
        fetch_enable = 1'b0;
        jump_enable  = 1'b0;
        clear_flags  = 1'b0;
        pc_m   = 20'h00500;
        viol_m = 1'b1;
        check_model("set_wins");
        do_clear();

        // Timeout then trap word pass-through
        do_jump(20'h00030);
        do_fetch(1'b0, '0, TMO);
        check_model("timeout");
        do_clear();
        do_fetch(1'b0, '0, 2);
        check_model("trap");

        // Two redirects: one in REQ, a newer one in DRAIN
        do_jump_fetch(20'h00100, 2, 3, 1'b1, 20'h00200);
        check_model("drain_rejump");

        // Reset mid-fetch
        fetch_enable = 1'b1;
        step();
        fetch_enable = 1'b0;
        check1("rst_mid_req", mem_req, 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        pc_m = '0; instr_m = '0; viol_m = 1'b0; corr_m = 1'b0;
        check1("rst_mid_req_low", mem_req, 1'b0);
        check1("rst_mid_busy", busy, 1'b0);
        check_model("rst_mid");
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        check1("rst_late_valid", instr_valid, 1'b0);

        // Randomized operation mix
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                do_fetch(($urandom_range(0, 3) == 0), W'($urandom_range(0, 'h5FF)),
                         $urandom_range(0, 3));
            end else if (kind <= 6) begin
                if (pc_m > LIMIT) do_jump(W'($urandom_range(0, 'h3FF)));
                do_jump_fetch(W'($urandom_range(0, 'h3FF)), $urandom_range(0, 3),
                              $urandom_range(1, 4), ($urandom_range(0, 1) == 1),
                              W'($urandom_range(0, 'h3FF)));
            end else if (kind == 7) begin
                if ($urandom_range(0, 2) == 0) begin
                    if (pc_m > LIMIT) do_jump(W'($urandom_range(0, 'h3FF)));
                    do_fetch(1'b0, '0, TMO);
                end else begin
                    do_jump(W'($urandom_range(0, 'h3FF)));
                end
            end else if (kind == 8) begin
                do_clear();
            end else begin
                mem_valid = 1'b1;
                step();
                mem_valid = 1'b0;
                check1("rand_stray_req", mem_req, 1'b0);
            end
            check_model("rand");
        end

        checkw("scoreboard_empty", W'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
